// File: rtl/add_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// add_seq_ctrl_pkg
//   Shared definitions for the multi-cycle add/subtract sequencer:
//   - state_t    : FSM state encodings ST_IDLE / ST_RUN / ST_DONE (2 bits)
//   - DEF_WIDTH  : default operand width, same value as the INPUTSIZE define
//   - DEF_CHUNK  : default slice width, same value as the GROUPSIZE define
//   - idx_width(): bit width of a slice index, never less than 1
// ----------------------------------------------------------------------------
package add_seq_ctrl_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // $clog2(1) is 0, but a zero-width index register is not legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_seq_ctrl_cla_chunk.sv
// ----------------------------------------------------------------------------
// cla_chunk
//   Combinational CHUNK-bit carry-lookahead slice adder built on a
//   Kogge-Stone group generate/propagate prefix tree.
//   Ports:
//     a, b  : slice operands (CHUNK bits)
//     cin   : carry into bit 0
//     sum   : slice sum (CHUNK bits)
//     cout  : carry out of the slice MSB
// ----------------------------------------------------------------------------
module cla_chunk
  import add_seq_ctrl_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // Returns {cout, sum}. Kept inside a function so the in-place prefix
  // update does not look like a combinational loop on a module signal.
  function automatic logic [CHUNK:0] cla_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             c0
  );
    logic [CHUNK-1:0] g;    // group generate, bits [i:i-span]
    logic [CHUNK-1:0] pg;   // group propagate
    logic [CHUNK-1:0] p;    // bit propagate (also the half-sum)
    logic [CHUNK-1:0] s;
    logic             c;
    g  = x & y;
    p  = x ^ y;
    pg = p;
    // NOTE: blocking assignments are correct here: each prefix level must
    // see the values the previous level just produced within this evaluation.
    // Walking i downward keeps g[i-d] / pg[i-d] at the previous level's value.
    for (int d = 1; d < CHUNK; d = d * 2) begin
      for (int i = CHUNK - 1; i >= d; i--) begin
        g[i]  = g[i] | (pg[i] & g[i-d]);
        pg[i] = pg[i] & pg[i-d];
      end
    end
    // g/pg[i] now span bits [i:0]; fold in the slice carry-in.
    for (int i = 0; i < CHUNK; i++) begin
      c    = (i == 0) ? c0 : (g[i-1] | (pg[i-1] & c0));
      s[i] = p[i] ^ c;
    end
    return {g[CHUNK-1] | (pg[CHUNK-1] & c0), s};
  endfunction

  always_comb begin
    {cout, sum} = cla_add(a, b, cin);
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// ----------------------------------------------------------------------------
// add_seq_ctrl
//   Multi-cycle WIDTH-bit add/subtract sequencer. One CHUNK-bit slice is
//   added per cycle, least significant first, with the inter-slice carry
//   held in a register. Valid/ready handshakes on request and result sides.
//   Optional feature (macro ADDSEQ_EARLY_DONE_EN): finish early once all
//   remaining operand slices are zero and no carry is pending.
//   Ports:
//     clk, rst_n            : clock (rising edge), async active-low reset
//     in_valid / in_ready   : request handshake
//     in_a, in_b, in_sub    : operands, in_sub=1 selects A-B
//     out_valid / out_ready : result handshake
//     out_sum, out_cout     : result and carry out (sub: 1 = no borrow)
//     out_ovf, out_zero     : signed overflow, result == 0
//     busy                  : sequencer not idle
// ----------------------------------------------------------------------------
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] result;

  int               slice_base;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] result_nxt;
  logic             last_slice;
`ifdef ADDSEQ_EARLY_DONE_EN
  logic             upper_zero;
`endif

  cla_chunk #(.CHUNK(CHUNK)) u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    slice_base = int'(idx) * CHUNK;
    slice_a    = opa[slice_base +: CHUNK];
    slice_b    = opb[slice_base +: CHUNK];
    result_nxt = result;
    result_nxt[slice_base +: CHUNK] = slice_sum;
    last_slice = (idx == LAST_IDX);
`ifdef ADDSEQ_EARLY_DONE_EN
    // Nothing above the current slice can change the result: stop here.
    // The result register was cleared at accept, so upper slices read zero.
    upper_zero = (((opa | opb) >> (slice_base + CHUNK)) == '0);
    last_slice = last_slice | (upper_zero & ~slice_cout);
`endif
  end

  // NOTE: every datapath register is reset as well as the FSM, because the
  // result outputs are required to read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      result   <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + 1: invert B and seed the carry.
            opa   <= in_a;
            opb   <= in_b ^ {WIDTH{in_sub}};
            carry <= in_sub;
            idx   <= '0;
`ifdef ADDSEQ_EARLY_DONE_EN
            result <= '0;
`endif
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          result <= result_nxt;
          carry  <= slice_cout;
          if (last_slice) begin
            // Result flags are captured once and held until the next finish.
            out_sum  <= result_nxt;
            out_cout <= slice_cout;
            out_zero <= (result_nxt == '0);
            out_ovf  <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                        (result_nxt[WIDTH-1] != opa[WIDTH-1]);
            state    <= ST_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add/subtract over several cycles using one narrow CHUNK-bit carry-lookahead slice adder.
- The slice adder is built on the group generate/propagate prefix tree.
- Each cycle it processes one slice, least significant first, and carries between slices in a register.
- Sits between the ALU issue logic and the shared adder datapath; uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, slice width per cycle; power of two, at least 2.
- NCHUNK, WIDTH/CHUNK, derived localparam, number of slices.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  1 = A-B, 0 = A+B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_sum == 0.
- busy  output  1  state != IDLE.

Behaviour:
- States:
  - IDLE: in_ready=1. On accept, latch opa=in_a, opb=in_b^{WIDTH{in_sub}}, carry=in_sub, idx=0; go to RUN.
  - RUN: slice adder computes opa[idx], opb[idx], carry. Sum is written to result slice idx; carry<=slice cout; idx<=idx+1. When idx==NCHUNK-1, go to DONE.
  - DONE: out_valid=1. On out_valid && out_ready, go to IDLE.
- Latency: out_valid rises NCHUNK cycles after the accept edge. Throughput is one operation per NCHUNK+2 cycles.
- in_ready=0 in RUN and DONE; in_valid is ignored there, and no accept occurs in the same cycle as an output handshake.
- Outputs in DONE come from registers and stay stable until the handshake:
  - out_cout = final carry.
  - out_ovf = (opa[MSB]==opb[MSB]) && (result[MSB]!=opa[MSB]).
  - out_zero = (result==0).
- out_sum/out_cout/out_ovf/out_zero hold their last value outside DONE. They are only meaningful while out_valid=1.
- idx is $clog2(NCHUNK) bits wide (minimum 1) and must not wrap before the DONE transition.
- NCHUNK==1: a single RUN cycle, then DONE.
- Reset (any time, including mid-RUN or in DONE): state=IDLE, idx=0, carry=0, result/opa/opb=0. Resulting outputs: out_valid=0, busy=0, in_ready=1, out_sum=0, out_cout=0, out_ovf=0, out_zero=0. An in-flight operation is discarded with no output.
- out_ready high while not in DONE: no effect.

Optional Feature:
- Macro ADDSEQ_EARLY_DONE_EN.
- Defined: in RUN, after slice idx, if opa and opb slices idx+1..NCHUNK-1 are all zero and the new carry is 0:
  - go directly to DONE;
  - upper result slices are cleared to 0 at accept, so they read zero.
  - Latency equals the number of RUN cycles executed (1..NCHUNK).
- Undefined: always NCHUNK RUN cycles; the result register is not cleared at accept.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE/ST_RUN/ST_DONE (2 bits);
  - default WIDTH/CHUNK constants, aligned with the existing INPUTSIZE/GROUPSIZE defines;
  - idx width function.
- One sub-module, cla_chunk: combinational CHUNK-bit carry-lookahead slice adder (a, b, cin -> sum, cout) built on the existing prefix tree. Instantiated once.

Test Plan (WIDTH=32, CHUNK=8, macro off unless noted):
- add 0x000000FF + 0x00000001 -> out_sum=0x00000100, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept edge.
- add 0xFFFFFFFF + 0x00000001 -> out_sum=0, cout=1, zero=1, ovf=0.
- sub 5-7 -> 0xFFFFFFFE, cout=0, ovf=0. sub 0x80000000-1 -> 0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, in_ready=0, no second accept; ready pulse -> IDLE next cycle, then accept.
- Assert rst_n low during RUN cycle 2 -> all outputs zero immediately, busy=0; after release in_ready=1 and a new add 2+3 returns 5.
- With ADDSEQ_EARLY_DONE_EN: add 3+4 -> out_sum=7 after 1 RUN cycle. Add 0x01000000+0x01000000 -> 0x02000000 after 4 cycles. sub 9-1 -> full 4 cycles.
